// File: rtl/rastro_grid_if.sv
// Handshake bundle between the light-cycle game logic and the player-1 trail grid.
interface rastro_grid_if;
  logic       clear;
  logic       pos_valid;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       busy;
  logic       collision;
  logic [7:0] trail_r;
  logic [7:0] trail_g;
  logic [7:0] trail_b;

  modport master (
    output clear, pos_valid, pos_x, pos_y, next_x, next_y,
    input  busy, collision, trail_r, trail_g, trail_b
  );
  modport slave (
    input  clear, pos_valid, pos_x, pos_y, next_x, next_y,
    output busy, collision, trail_r, trail_g, trail_b
  );
endinterface

// File: rtl/rastro_grid.sv
// Player-1 trail memory: 1-bit occupancy per 8x8 cell, move collision check on
// port A and a registered per-pixel trail colour lookup on port B.
module rastro_grid #(
  parameter int GRID_W     = 80,
  parameter int GRID_H     = 60,
  parameter int CELL_SHIFT = 3,
  parameter int TRAIL_R    = 255,
  parameter int TRAIL_G    = 128,
  parameter int TRAIL_B    = 0
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  rastro_grid_if.slave  bus
);
  localparam int              CELLS = GRID_W * GRID_H;
  localparam int              AW    = $clog2(CELLS);
  localparam logic [9:0]      GW    = 10'(GRID_W);
  localparam logic [9:0]      GH    = 10'(GRID_H);
  localparam logic [AW-1:0]   LAST  = AW'(CELLS - 1);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_CHECK, S_DEAD} state_t;

  function automatic logic [AW-1:0] cell_addr(input logic [9:0] cx, input logic [9:0] cy);
    return AW'(cy) * AW'(GRID_W) + AW'(cx);
  endfunction

  state_t          r_state, w_nstate;
  logic [AW-1:0]   r_clr_addr;
  logic [AW-1:0]   r_addr;
  logic            r_coll;
  logic            r_rd_a;
  logic            r_rd_b;
  logic            r_inb_b;
  logic            r_mem [0:CELLS-1];

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic            w_wdata;

  // Move position -> cell; out-of-range addresses are steered to 0 so the
  // RAM is never indexed past its end.
  logic [9:0]      w_pcx, w_pcy, w_ncx, w_ncy;
  logic            w_pinb, w_ninb;
  logic [AW-1:0]   w_paddr, w_naddr;

  assign w_pcx   = bus.pos_x >> CELL_SHIFT;
  assign w_pcy   = bus.pos_y >> CELL_SHIFT;
  assign w_pinb  = (w_pcx < GW) && (w_pcy < GH);
  assign w_paddr = w_pinb ? cell_addr(w_pcx, w_pcy) : '0;

  assign w_ncx   = bus.next_x >> CELL_SHIFT;
  assign w_ncy   = bus.next_y >> CELL_SHIFT;
  assign w_ninb  = (w_ncx < GW) && (w_ncy < GH);
  assign w_naddr = w_ninb ? cell_addr(w_ncx, w_ncy) : '0;

  always_comb begin
    w_nstate = r_state;
    w_we     = 1'b0;
    w_waddr  = r_clr_addr;
    w_wdata  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        if (r_clr_addr == LAST) w_nstate = S_RUN;
      end
      S_RUN: begin
        if (bus.pos_valid) w_nstate = w_pinb ? S_CHECK : S_DEAD;
      end
      S_CHECK: begin
        if (r_rd_a) begin
          w_nstate = S_DEAD;
        end else begin
          w_we     = 1'b1;
          w_waddr  = r_addr;
          w_wdata  = 1'b1;
          w_nstate = S_RUN;
        end
      end
      default: w_nstate = S_DEAD;
    endcase
    // Restart wins over everything, including a pending CHECK write.
    if (reset || bus.clear) begin
      w_nstate = S_CLEAR;
      w_we     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    r_state <= w_nstate;
    if (reset || bus.clear) begin
      r_clr_addr <= '0;
      r_coll     <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (r_state == S_RUN && bus.pos_valid && !w_pinb) r_coll <= 1'b1;
      if (r_state == S_CHECK && r_rd_a) r_coll <= 1'b1;
    end
    if (r_state == S_RUN && bus.pos_valid) r_addr <= w_paddr;
  end

  // Dual-port RAM; port B reads the pre-write value on an address clash.
  always_ff @(posedge CLOCK_50) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd_a  <= r_mem[w_paddr];
    r_rd_b  <= r_mem[w_naddr];
    r_inb_b <= w_ninb;
  end

  logic w_show;
  assign w_show        = r_rd_b && r_inb_b && (r_state != S_CLEAR);
  assign bus.busy      = (r_state == S_CLEAR) || (r_state == S_CHECK);
  assign bus.collision = r_coll;
  assign bus.trail_r   = w_show ? 8'(TRAIL_R) : 8'd0;
  assign bus.trail_g   = w_show ? 8'(TRAIL_G) : 8'd0;
  assign bus.trail_b   = w_show ? 8'(TRAIL_B) : 8'd0;
endmodule

// File: tb/tb_rastro_grid.sv
// Randomized bench for rastro_grid against an array-based occupancy model.
module tb_rastro_grid;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rastro_grid_if bus ();

  rastro_grid dut (.CLOCK_50(clk), .reset(rst), .bus(bus.slave));

  always #10 clk = ~clk;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  m_grid [4800];
  bit  m_dead;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] trail_of(input int x, input int y);
    int cx = x / 8;
    int cy = y / 8;
    if (cx < 80 && cy < 60 && m_grid[cy*80 + cx]) return 24'hFF8000;
    return 24'h0;
  endfunction

  task automatic pix(input string tag, input int x, input int y);
    bus.next_x = 10'(x);
    bus.next_y = 10'(y);
    tick();
    chk(tag, {8'h0, bus.trail_r, bus.trail_g, bus.trail_b}, {8'h0, trail_of(x, y)});
  endtask

  // One random pixel per cell plus a few off-screen probes.
  task automatic scan(input string tag);
    for (int cy = 0; cy < 60; cy++)
      for (int cx = 0; cx < 80; cx++)
        pix(tag, cx*8 + int'($urandom_range(0, 7)), cy*8 + int'($urandom_range(0, 7)));
    for (int i = 0; i < 8; i++)
      pix(tag, int'($urandom_range(640, 1023)), int'($urandom_range(0, 1023)));
  endtask

  // Count busy cycles from the first post-restart sample; injects a stray move mid-sweep.
  task automatic wait_clear(input string tag, input bit inject);
    int n = 0;
    while (bus.busy && n < 6000) begin
      if (inject && n == 100) begin
        bus.pos_valid = 1'b1; bus.pos_x = 10'd8; bus.pos_y = 10'd8;
      end
      tick();
      bus.pos_valid = 1'b0;
      n++;
    end
    chk(tag, n, 4800);
    chk({tag, "_coll"}, bus.collision, 1'b0);
    foreach (m_grid[i]) m_grid[i] = 1'b0;
    m_dead = 1'b0;
  endtask

  task automatic do_clear(input string tag, input bit inject);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1'b1);
    wait_clear(tag, inject);
  endtask

  task automatic move(input string tag, input int x, input int y);
    int  cx = x / 8;
    int  cy = y / 8;
    bit  inb = (cx < 80) && (cy < 60);
    bit  hit;
    bus.pos_valid = 1'b1;
    bus.pos_x = 10'(x);
    bus.pos_y = 10'(y);
    tick();
    bus.pos_valid = 1'b0;
    if (m_dead) begin
      chk({tag, "_dead_busy"}, bus.busy, 1'b0);
      tick();
      chk({tag, "_dead_coll"}, bus.collision, 1'b1);
    end else if (!inb) begin
      chk({tag, "_oob_coll"}, bus.collision, 1'b1);
      chk({tag, "_oob_busy"}, bus.busy, 1'b0);
      m_dead = 1'b1;
    end else begin
      chk({tag, "_busy1"}, bus.busy, 1'b1);
      chk({tag, "_coll_n1"}, bus.collision, 1'b0);
      tick();
      chk({tag, "_busy0"}, bus.busy, 1'b0);
      hit = m_grid[cy*80 + cx];
      chk({tag, "_coll"}, bus.collision, hit);
      if (hit) m_dead = 1'b1;
      else m_grid[cy*80 + cx] = 1'b1;
    end
  endtask

  initial begin
    int cx, cy;
    bus.clear = 1'b0; bus.pos_valid = 1'b0;
    bus.pos_x = '0; bus.pos_y = '0; bus.next_x = '0; bus.next_y = '0;
    tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_coll", bus.collision, 1'b0);
    chk("rst_trail", {bus.trail_r, bus.trail_g, bus.trail_b}, 24'h0);
    wait_clear("rst_len", 1'b0);
    scan("scan_empty");

    move("mv_219", 219, 239);
    pix("px_216_232", 216, 232);
    pix("px_223_239", 223, 239);
    pix("px_224_239", 224, 239);
    pix("px_216_231", 216, 231);
    chk("px_lit", {bus.trail_r, bus.trail_g, bus.trail_b}, 24'h0);

    for (int i = 0; i < 25; i++) begin
      do begin
        cx = int'($urandom_range(0, 79));
        cy = int'($urandom_range(0, 59));
      end while (m_grid[cy*80 + cx] || (cx == 37 && cy == 12));
      move("mv_rnd", cx*8 + int'($urandom_range(0, 7)), cy*8 + int'($urandom_range(0, 7)));
    end
    scan("scan_rnd");

    move("mv_again", 219, 239);
    move("mv_dead", 300, 100);
    pix("px_dead_dark", 300, 100);
    scan("scan_dead");

    do_clear("clr_oob1", 1'b0);
    move("oob_x640", 640, 0);
    pix("px_oob", 0, 0);
    do_clear("clr_oob2", 1'b0);
    move("oob_y480", 0, 480);
    do_clear("clr_oob3", 1'b0);
    move("oob_x1020", 1020, 100);
    pix("px_1020", 1020, 100);
    do_clear("clr_oob4", 1'b0);
    move("oob_rnd", int'($urandom_range(640, 1023)), int'($urandom_range(0, 479)));

    // Stray move during the sweep must be dropped.
    do_clear("clr_inj", 1'b1);
    pix("px_inj_dark", 8, 8);

    // Second strobe held into the CHECK cycle must be dropped.
    bus.pos_valid = 1'b1; bus.pos_x = 10'd16; bus.pos_y = 10'd16;
    tick();
    chk("chk_drop_busy", bus.busy, 1'b1);
    bus.pos_x = 10'd24;
    tick();
    bus.pos_valid = 1'b0;
    chk("chk_drop_busy0", bus.busy, 1'b0);
    chk("chk_drop_coll", bus.collision, 1'b0);
    m_grid[2*80 + 2] = 1'b1;
    pix("px_16_16", 16, 16);
    pix("px_24_16", 24, 16);

    move("mark_a", 100, 100);
    move("mark_b", 400, 300);
    move("mark_c", 600, 20);
    bus.pos_valid = 1'b1; bus.pos_x = 10'd500; bus.pos_y = 10'd400;
    tick();
    bus.pos_valid = 1'b0;
    chk("abandon_busy", bus.busy, 1'b1);
    do_clear("clr_abandon", 1'b0);
    scan("scan_final");
    pix("px_abandon", 500, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
